// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the eight-digit seven-segment scanner.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS  = 8;
  localparam logic [7:0]  ANODE_OFF   = 8'hFF;
  localparam logic [7:0]  ANODE_FIRST = 8'hFE;

  localparam logic [6:0] SEG_BLANK = 7'b111_1111;
  localparam logic [6:0] SEG_0     = 7'b100_0000;
  localparam logic [6:0] SEG_1     = 7'b111_1001;
  localparam logic [6:0] SEG_2     = 7'b010_0100;
  localparam logic [6:0] SEG_3     = 7'b011_0000;
  localparam logic [6:0] SEG_4     = 7'b001_1001;
  localparam logic [6:0] SEG_5     = 7'b001_0010;
  localparam logic [6:0] SEG_6     = 7'b000_0010;
  localparam logic [6:0] SEG_7     = 7'b111_1000;
  localparam logic [6:0] SEG_8     = 7'b000_0000;
  localparam logic [6:0] SEG_9     = 7'b001_0000;
  localparam logic [6:0] SEG_A     = 7'b000_1000;
  localparam logic [6:0] SEG_B     = 7'b000_0011;
  localparam logic [6:0] SEG_C     = 7'b100_0110;
  localparam logic [6:0] SEG_D     = 7'b010_0001;
  localparam logic [6:0] SEG_E     = 7'b000_0110;
  localparam logic [6:0] SEG_F     = 7'b000_1110;

  // A legal ring position has exactly one anode driven low.
  function automatic logic an_in_ring(input logic [7:0] an);
    return $countones(~an) == 1;
  endfunction

  function automatic logic [2:0] an_to_digit(input logic [7:0] an);
    logic [2:0] idx;
    idx = 3'd0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (!an[k]) idx = 3'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed eight-digit seven-segment driver with registered pins.
// Optional leading-zero blanking: define SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data,
  input  logic [7:0]  dp_en,
  input  logic        load,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n
);

  localparam int unsigned CntW = $clog2(TICK_DIV);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick;
  logic [31:0]     data_q;
  logic [7:0]      dp_q;
  logic [7:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d, seg_dec;
  logic            dp_n_q, dp_n_d;
  logic [2:0]      digit_idx;
  logic [3:0]      nibble;
  logic            blank;

  always_comb begin
    tick  = (cnt_q == CntW'(TICK_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CntW'(1);
  end

  // Out-of-ring values (including the blanked reset state) re-enter at digit 0.
  always_comb begin
    an_d      = an_in_ring(an_q) ? {an_q[6:0], an_q[7]} : ANODE_FIRST;
    digit_idx = an_to_digit(an_d);
    nibble    = data_q[{digit_idx, 2'b00} +: 4];
  end

  seg7_decode u_decode (
    .nibble_i (nibble),
    .seg_o    (seg_dec)
  );

  always_comb begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    blank = (digit_idx != 3'd0) && ((data_q >> {digit_idx, 2'b00}) == 32'd0);
`else
    blank = 1'b0;
`endif
    seg_d  = blank ? SEG_BLANK : seg_dec;
    dp_n_d = ~dp_q[digit_idx];
  end

  // Pins change only on tick, so a load shows up at the following tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      data_q <= '0;
      dp_q   <= '0;
      an_q   <= ANODE_OFF;
      seg_q  <= SEG_BLANK;
      dp_n_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      if (load) begin
        data_q <= data;
        dp_q   <= dp_en;
      end
      if (tick) begin
        an_q   <= an_d;
        seg_q  <= seg_d;
        dp_n_q <= dp_n_d;
      end
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp_n = dp_n_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan at TICK_DIV=4: vector table, corner sequences, random run.
module tb_seg7_scan;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        reset, load;
  logic [31:0] data;
  logic [7:0]  dp_en;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp_n;

  seg7_scan #(.TICK_DIV(TD)) dut (
    .clk   (clk),
    .reset (reset),
    .data  (data),
    .dp_en (dp_en),
    .load  (load),
    .an    (an),
    .seg   (seg),
    .dp_n  (dp_n)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  int          m_cnt, m_pos;
  logic        m_tick;
  logic [31:0] m_disp;
  logic [7:0]  m_dpr, m_an;
  logic [6:0]  m_seg;
  logic        m_dp;
  logic [6:0]  hex_tab [16];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  typedef struct {
    logic [31:0] d;
    logic [7:0]  e;
    int          k;
    logic [6:0]  s;
    logic        p;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] model_seg(input int p);
    logic [31:0] rest;
    logic [6:0]  s;
    rest = m_disp >> (4 * p);
    s = hex_tab[rest[3:0]];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (p > 0 && rest == 32'd0) s = 7'h7F;
`endif
    return s;
  endfunction

  function automatic void model_edge(input logic r, input logic l, input logic [31:0] d,
                                     input logic [7:0] e);
    if (r) begin
      m_cnt = 0; m_pos = -1; m_disp = '0; m_dpr = '0; m_tick = 1'b0;
      m_an = 8'hFF; m_seg = 7'h7F; m_dp = 1'b1;
    end else begin
      m_tick = (m_cnt == TD - 1);
      m_cnt  = (m_cnt + 1) % TD;
      if (m_tick) begin
        m_pos = (m_pos + 1) % 8;
        m_an  = ~(8'h01 << m_pos);
        m_seg = model_seg(m_pos);
        m_dp  = ~m_dpr[m_pos];
      end
      if (l) begin
        m_disp = d;
        m_dpr  = e;
      end
    end
  endfunction

  task automatic step(input logic r, input logic l, input logic [31:0] d, input logic [7:0] e);
    reset = r; load = l; data = d; dp_en = e;
    @(posedge clk);
    model_edge(r, l, d, e);
    #1;
    check("an", {24'd0, an}, {24'd0, m_an});
    check("seg", {25'd0, seg}, {25'd0, m_seg});
    check("dp_n", {31'd0, dp_n}, {31'd0, m_dp});
    reset = 1'b0; load = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, data, dp_en);
  endtask

  // Advance until the next edge is a tick edge.
  task automatic to_pre_tick(input string nm);
    int n = 0;
    while (m_cnt != TD - 1 && n < 2 * TD) begin idle(); n++; end
    if (m_cnt != TD - 1) check(nm, 32'd0, 32'd1);
  endtask

  task automatic to_digit(input int k, input string nm);
    int n = 0;
    while (!(m_tick && m_pos == k) && n < 10 * TD * 8) begin idle(); n++; end
    if (!(m_tick && m_pos == k)) check(nm, 32'd0, 32'd1);
  endtask

  function automatic void add(input logic [31:0] d, input logic [7:0] e, input int k,
                              input logic [6:0] s, input logic p);
    vec_t v;
    v.d = d; v.e = e; v.k = k; v.s = s; v.p = p;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [7:0] ring [8];
    int         t;
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    ring    = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    reset = 1'b1; load = 1'b0; data = '0; dp_en = '0;

    // Reset state
    step(1'b1, 1'b0, 32'hFFFF_FFFF, 8'hFF);
    step(1'b1, 1'b1, 32'hFFFF_FFFF, 8'hFF);
    check("reset_an", {24'd0, an}, 32'hFF);
    check("reset_seg", {25'd0, seg}, 32'h7F);
    check("reset_dp", {31'd0, dp_n}, 32'd1);

    // Free-running scan with no load: full ring plus wrap
    t = 0;
    for (int i = 0; i < 40; i++) begin
      idle();
      if (m_tick) begin
        check("ring_an", {24'd0, an}, {24'd0, ring[t % 8]});
        check("ring_dp", {31'd0, dp_n}, 32'd1);
        t++;
      end
    end
    check("ring_ticks", t, 10);

    // Vector table: load, then look at a chosen digit
    add(32'h89AB_CDEF, 8'h01, 0, 7'h0E, 1'b0);
    add(32'h89AB_CDEF, 8'h01, 7, 7'h00, 1'b1);
    add(32'h7654_3210, 8'h00, 0, 7'h40, 1'b1);
    add(32'h7654_3210, 8'h00, 1, 7'h79, 1'b1);
    add(32'h7654_3210, 8'h00, 2, 7'h24, 1'b1);
    add(32'h7654_3210, 8'h00, 3, 7'h30, 1'b1);
    add(32'h7654_3210, 8'h00, 4, 7'h19, 1'b1);
    add(32'h7654_3210, 8'h00, 5, 7'h12, 1'b1);
    add(32'h7654_3210, 8'h00, 6, 7'h02, 1'b1);
    add(32'h7654_3210, 8'h00, 7, 7'h78, 1'b1);
    add(32'hFEDC_BA98, 8'hFF, 0, 7'h00, 1'b0);
    add(32'hFEDC_BA98, 8'hFF, 1, 7'h10, 1'b0);
    add(32'hFEDC_BA98, 8'hFF, 2, 7'h08, 1'b0);
    add(32'hFEDC_BA98, 8'hFF, 3, 7'h03, 1'b0);
    add(32'hFEDC_BA98, 8'hFF, 4, 7'h46, 1'b0);
    add(32'hFEDC_BA98, 8'hFF, 5, 7'h21, 1'b0);
    add(32'hFEDC_BA98, 8'hFF, 6, 7'h06, 1'b0);
    add(32'hFEDC_BA98, 8'hFF, 7, 7'h0E, 1'b0);
    add(32'h0000_0A05, 8'h00, 0, 7'h12, 1'b1);
    add(32'h0000_0A05, 8'h00, 1, 7'h40, 1'b1);
    add(32'h0000_0A05, 8'h00, 2, 7'h08, 1'b1);
    add(32'h0000_0A05, 8'h00, 3, LZ, 1'b1);
    add(32'h0000_0A05, 8'h00, 7, LZ, 1'b1);
    add(32'h0000_0000, 8'h00, 0, 7'h40, 1'b1);
    add(32'h0000_0000, 8'h00, 1, LZ, 1'b1);
    add(32'h0000_0000, 8'h00, 6, LZ, 1'b1);
    add(32'hA5A5_5A5A, 8'h80, 7, 7'h08, 1'b0);
    foreach (vecs[i]) begin
      step(1'b0, 1'b1, vecs[i].d, vecs[i].e);
      to_digit(vecs[i].k, "vec_timeout");
      check($sformatf("vec%0d_seg", i), {25'd0, seg}, {25'd0, vecs[i].s});
      check($sformatf("vec%0d_dp", i), {31'd0, dp_n}, {31'd0, vecs[i].p});
    end

    // Load coinciding with tick: old value this tick, new value next tick
    step(1'b0, 1'b1, 32'h2222_2222, 8'h00);
    to_pre_tick("lt_timeout");
    step(1'b0, 1'b1, 32'h3333_3333, 8'hFF);
    check("lt_old_seg", {25'd0, seg}, 32'h24);
    check("lt_old_dp", {31'd0, dp_n}, 32'd1);
    to_pre_tick("lt_timeout2");
    idle();
    check("lt_new_seg", {25'd0, seg}, 32'h30);
    check("lt_new_dp", {31'd0, dp_n}, 32'd0);

    // Reset mid-scan while digit 4 is selected
    to_digit(4, "mid_timeout");
    check("mid_an", {24'd0, an}, 32'hEF);
    step(1'b1, 1'b0, 32'h0, 8'h0);
    check("mid_rst_an", {24'd0, an}, 32'hFF);
    check("mid_rst_seg", {25'd0, seg}, 32'h7F);
    to_pre_tick("mid_timeout2");
    idle();
    check("mid_first_an", {24'd0, an}, 32'hFE);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic        r, l;
      logic [31:0] d;
      r = ($urandom_range(0, 199) == 0);
      l = ($urandom_range(0, 5) == 0);
      d = $urandom >> (4 * $urandom_range(0, 7));
      step(r, l, d, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000, clock cycles per digit slot (legal range 2..2^24).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port data  input  32  eight hex nibbles to display; nibble k = data[4k+3:4k] drives digit k.
REQ-005 SHALL have port dp_en  input  8  decimal-point enables; bit k applies to digit k.
REQ-006 SHALL have port load  input  1  single-cycle strobe that captures data and dp_en.
REQ-007 SHALL have port an  output  8  anode selects, active-low, at most one bit low.
REQ-008 SHALL have port seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-009 SHALL have port dp_n  output  1  decimal-point cathode, active-low.

Function
REQ-010 SHALL count with a prescaler from 0 to TICK_DIV-1 and then wrap to 0; tick is high in the cycle where the count equals TICK_DIV-1.
REQ-011 SHALL, when load=1, capture data and dp_en into display registers on that clock edge, independent of tick.
REQ-012 SHALL, on tick, advance an per this ring: 1111_1110 -> 1111_1101 -> 1111_1011 -> 1111_0111 -> 1110_1111 -> 1101_1111 -> 1011_1111 -> 0111_1111 -> 1111_1110.
REQ-013 SHALL, on tick, move any an value outside the ring (including the reset value 1111_1111) to 1111_1110.
REQ-014 SHALL hold an unchanged when tick=0.
REQ-015 SHALL register an, seg and dp_n and update all three on the same edge; seg/dp_n SHALL reflect the newly selected digit, with no cycle of mismatch.
REQ-016 SHALL compute seg from the display-register nibble of the new digit using active-low hex encoding: 0=100_0000, 1=111_1001, 2=010_0100, 3=011_0000, 4=001_1001, 5=001_0010, 6=000_0010, 7=111_1000, 8=000_0000, 9=001_0000, A=000_1000, b=000_0011, C=100_0110, d=010_0001, E=000_0110, F=000_1110.
REQ-017 SHALL set dp_n = ~dp_en_reg[k] for the new digit k.
REQ-018 SHALL make a load visible on the pins at the next tick only; worst-case latency is TICK_DIV cycles.
REQ-019 SHALL, when load and tick fall on the same edge, capture the loaded value and use the old display-register value for that tick's seg.

Reset
REQ-020 SHALL, on reset, set an=1111_1111, seg=111_1111, dp_n=1, prescaler=0, display data=0 and dp_en_reg=0.
REQ-021 SHALL give reset priority over load and tick.
REQ-022 SHALL, on the first tick after reset release, drive an=1111_1110.
REQ-023 SHALL, if reset is asserted mid-scan, blank the outputs on the next edge, and scanning SHALL restart at digit 0.

Configuration
REQ-024 SHALL, when macro SEG7_LEADING_ZERO_BLANK_EN is defined, drive seg=111_1111 for digit k>0 whenever display nibbles k..7 are all zero.
REQ-025 SHALL keep digit 0 and dp_n unaffected by leading-zero blanking.
REQ-026 SHALL, without SEG7_LEADING_ZERO_BLANK_EN, display all eight digits unconditionally.

Structure
REQ-027 SHALL put the following in shared package seg7_pkg: the segment-pattern constants, ANODE_OFF=8'hFF, ANODE_FIRST=8'hFE, and the digit-count constant NUM_DIGITS=8.
REQ-028 SHALL implement the nibble-to-segment decode as sub-module seg7_decode: 4-bit in, 7-bit active-low out, purely combinational.
REQ-029 SHALL keep the prescaler, ring register, display registers and output registers in seg7_scan.

Verification (TICK_DIV=4)
REQ-030 Reset, then run 40 cycles with no load -> an steps FE,FD,FB,F7,EF,DF,BF,7F,FE every 4 cycles; seg=100_0000 throughout; dp_n=1.
REQ-031 Load data=32'h89AB_CDEF, dp_en=8'h01 -> digit 0 shows seg=000_1110 with dp_n=0; digit 7 shows seg=000_0000 with dp_n=1.
REQ-032 Pulse load in the same cycle as tick -> that tick shows the old value; the following tick shows the new value.
REQ-033 Assert reset while an=1110_1111 -> next edge gives an=FF and seg=7F; the first tick after release gives an=FE.
REQ-034 With SEG7_LEADING_ZERO_BLANK_EN defined, load data=32'h0000_0A05 -> digits 3..7 give seg=111_1111; digit 2 gives 000_1000; digit 1 gives 100_0000; digit 0 gives 001_0010.
REQ-035 Load data=0 with SEG7_LEADING_ZERO_BLANK_EN defined -> only digit 0 lit, with seg=100_0000; without the macro, all eight digits show 100_0000.
